muldiv_ctrl: RTL

Iterative multiply/divide sequencer that owns the HI/LO register pair for the single-cycle MIPS core. It accepts MULT/MULTU/DIV/DIVU from the control unit, runs a radix-2 shift-add or restoring shift-subtract over WIDTH cycles, and writes HI/LO. Its `busy` output gates the PC write enable so that MFHI/MFLO and further mul/div instructions stall until results are valid. MTHI/MTLO writes also pass through this block.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_if.sv | 30 +++
 rtl/muldiv_step.sv | 30 +++
 rtl/muldiv_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the control unit and the mul/div sequencer.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output busy, done, div_zero, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               mode,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]}
               + (acc[0] ? {1'b0, operand} : '0);
        rem_sh = acc[2*WIDTH-1:WIDTH-1];
        // remainder < divisor keeps rem_sh < 2*divisor, so bit WIDTH is the borrow
        diff   = rem_sh - {1'b0, operand};
        q_bit    = 1'b0;
        acc_next = {sum, acc[WIDTH-1:1]};
        if (mode) begin
            q_bit    = ~diff[WIDTH];
            acc_next = {(q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                        acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner: iterative MULT(U)/DIV(U) sequencer with MTHI/MTLO.
// MULDIV_SIGNED_EN builds the signed abs/negate path; otherwise all ops are unsigned.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_e             state;
    state_e             state_nx;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               q_bit;
    logic               div0;
    logic               done_q;
    logic               dz_q;

    assign div0         = bus.op[1] && (bus.b == '0);
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

`ifdef MULDIV_SIGNED_EN
    logic               sgn;
    logic               neg_res;
    logic               neg_rem;
    logic [2*WIDTH-1:0] prod;

    assign sgn   = bus.op[0];
    assign a_abs = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_abs = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign prod  = neg_res ? -acc : acc;

    always_comb begin
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div) begin
            fix_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            fix_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else if (state == IDLE && bus.start && !div0) begin
            neg_res <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem <= sgn & bus.a[WIDTH-1];
        end
    end
`else
    logic unused_op0;

    assign unused_op0 = bus.op[0];
    assign a_abs      = bus.a;
    assign b_abs      = bus.b;
    assign fix_hi     = acc[2*WIDTH-1:WIDTH];
    assign fix_lo     = acc[WIDTH-1:0];
`endif

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .mode    (is_div),
        .acc     (acc),
        .operand (opnd),
        .acc_next(acc_nx),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start && !div0) state_nx = CALC;
            CALC:    if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            is_div <= 1'b0;
            acc    <= '0;
            opnd   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (div0) begin
                            dz_q   <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            dz_q   <= 1'b0;
                            is_div <= bus.op[1];
                            cnt    <= '0;
                            acc    <= {{WIDTH{1'b0}},
                                       (bus.op[1] ? a_abs : b_abs)};
                            opnd   <= bus.op[1] ? b_abs : a_abs;
                        end
                    end else begin
                        if (bus.mthi) hi_q <= bus.wdata;
                        if (bus.mtlo) lo_q <= bus.wdata;
                    end
                end
                CALC: begin
                    acc <= {acc_nx[2*WIDTH-1:1], acc_nx[0] | q_bit};
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    hi_q   <= fix_hi;
                    lo_q   <= fix_lo;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
